uart_mmio_tx: RTL and testbench
===============================

UART_MMIO_TX -- requirements
Module: uart_mmio_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: transmit buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: clock; all logic on posedge clk.
REQ-004 SHALL have port Rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port mmio_wea, input, 1: core MMIO write strobe, one byte pushed per asserted cycle.
REQ-006 SHALL have port mmio_dat, input, 32: write data; bits [7:0] transmitted, bits [31:8] ignored.
REQ-007 SHALL have port tx, output, 1: serial line, 8N1, idle high.
REQ-008 SHALL have port tx_busy, output, 1: high while a frame is in progress or the buffer is non-empty.
REQ-009 SHALL have port tx_full, output, 1: buffer full; a write in this cycle is dropped.
REQ-010 SHALL have port tx_overflow, output, 1: sticky flag set by a dropped write.

Function
REQ-011 SHALL accept a write when mmio_wea=1 and registered tx_full=0, storing mmio_dat[7:0] at the buffer tail.
REQ-012 SHALL drop a write when tx_full=1, even if a pop occurs in the same cycle, and set tx_overflow on the next edge.
REQ-013 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-014 IDLE: tx=1; when the buffer is non-empty, SHALL pop the head into the shift register and enter START on the next edge.
REQ-015 START: tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-016 DATA: SHALL drive bits LSB first, each for exactly CLKS_PER_BIT cycles; after bit 7, enter STOP.
REQ-017 STOP: tx=1 for exactly CLKS_PER_BIT cycles; then, if the buffer is non-empty, SHALL pop and enter START directly with no idle gap; otherwise enter IDLE.
REQ-018 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-019 First-byte latency: a write accepted at edge N into an empty idle block SHALL cause tx to fall at edge N+2.
REQ-020 SHALL use a baud counter counting 0..CLKS_PER_BIT-1, reloading to 0 on every state or bit change.
REQ-021 tx SHALL be driven from a register, with no combinational path from inputs.
REQ-022 Buffer pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL range 0..FIFO_DEPTH, with full at count=FIFO_DEPTH.
REQ-023 On a simultaneous push and pop with count not full, count SHALL be unchanged and both operations SHALL take effect.
REQ-024 tx_busy SHALL be 0 only when the FSM is in IDLE and the buffer is empty.

Reset
REQ-025 On Rst=1 at a clock edge: FSM=IDLE, tx=1, pointers and count=0, tx_full=0, tx_busy=0, tx_overflow=0, baud counter=0.
REQ-026 Rst asserted mid-frame SHALL abort the frame immediately (tx=1 on the next edge) and discard all buffered bytes.
REQ-027 Rst SHALL take priority over mmio_wea in the same cycle; the write is discarded.

Configuration
REQ-028 Macro UART_TX_FIFO_EN defined: SHALL use the FIFO_DEPTH-entry buffer as specified above.
REQ-029 UART_TX_FIFO_EN undefined: SHALL use a single holding register, with tx_full equal to the holding-valid flag and FIFO_DEPTH ignored; all other behaviour is identical.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum uart_tx_state_t (IDLE, START, DATA, STOP) and the constants UART_DATA_BITS=8 and UART_DEFAULT_CLKS_PER_BIT=868.
REQ-031 The buffer SHALL be a sub-module uart_tx_fifo (push, pop, din, dout, empty, full), instantiated only under UART_TX_FIFO_EN.

Verification (bench CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Write 0x000000A5 once -> tx pattern 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx falls 2 cycles after the accept edge; tx_busy clears after 40 cycles.
REQ-033 Write 0x55 then 0x0F on consecutive cycles -> two frames of 80 cycles total; the second start bit immediately follows the first stop bit.
REQ-034 Write 6 bytes 0x01..0x06 on consecutive cycles while idle -> 0x01 popped after the first write, 0x02..0x05 fill the buffer, tx_full=1 at the sixth write, 0x06 dropped, tx_overflow=1; the serial output is 0x01..0x05.
REQ-035 Assert Rst at cycle 17 of a 0xFF frame -> tx=1 on the next edge, buffer empty, tx_busy=0, no further frames.
REQ-036 Write 0xDEADBE42 -> only 0x42 transmitted.
REQ-037 Build without UART_TX_FIFO_EN: a second write during a frame is accepted; a third write is dropped and tx_overflow=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // A push while full is refused even if a pop happens in the same cycle.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/uart_mmio_tx.sv
// MMIO-fed 8N1 UART transmitter. Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry
// buffer; otherwise a single holding register buffers the next byte.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high), then chain to the next byte or go idle
module uart_mmio_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mmio_wea,
  input  logic [31:0] mmio_dat,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_full,
  output logic        tx_overflow
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uart_tx_state_t r_state;
  logic [BW-1:0]  r_baud;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic           r_overflow;
  logic           w_baud_end;
  logic           w_push;
  logic           w_pop;
  logic           w_empty;
  logic           w_full;
  logic [7:0]     w_dout;
  logic           w_unused_dat;

  assign w_unused_dat = ^mmio_dat[31:8];
  assign w_baud_end   = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_push       = mmio_wea & ~w_full;
  assign w_pop        = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_baud_end));

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .Rst   (Rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (mmio_dat[7:0]),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full)
  );
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;

  logic [7:0] r_hold;
  logic       r_hold_vld;

  // Push needs an empty holder and pop needs a full one, so they never coincide.
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_hold_vld <= 1'b0;
    end else if (w_push) begin
      r_hold     <= mmio_dat[7:0];
      r_hold_vld <= 1'b1;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end

  assign w_empty = ~r_hold_vld;
  assign w_full  = r_hold_vld;
  assign w_dout  = r_hold;
`endif

  // tx is registered from the current state, so it lags the state by one edge.
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (mmio_wea & w_full) r_overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_dout;
            r_state <= START;
          end
        end
        START: begin
          r_tx <= 1'b0;
          if (w_baud_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          r_tx <= r_shift[0];
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit_idx == 3'(UART_DATA_BITS - 1)) r_state <= STOP;
            else r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_dout;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx          = r_tx;
  assign tx_busy     = ~((r_state == IDLE) & w_empty);
  assign tx_full     = w_full;
  assign tx_overflow = r_overflow;

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Self-checking bench for uart_mmio_tx: table-driven frames, directed corner sequences
// and random traffic against a timing-level reference model; honours UART_TX_FIFO_EN.
module tb_uart_mmio_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        mmio_wea = 1'b0;
  logic [31:0] mmio_dat = '0;
  logic        tx;
  logic        tx_busy;
  logic        tx_full;
  logic        tx_overflow;

  uart_mmio_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .Rst         (Rst),
    .mmio_wea    (mmio_wea),
    .mmio_dat    (mmio_dat),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_full     (tx_full),
    .tx_overflow (tx_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: buffered bytes plus the edge at which the current frame was popped.
  logic [7:0] m_q[$];
  bit         m_have = 0;
  int         m_start = 0;
  logic [7:0] m_byte = '0;
  bit         m_ovf = 0;

  function automatic void model_edge(logic rst, logic wea, logic [7:0] d);
    int occ;
    bit do_pop;
    if (rst) begin
      m_q.delete();
      m_have = 0;
      m_ovf  = 0;
      return;
    end
    occ    = m_q.size();
    do_pop = (occ > 0) && (!m_have || cyc >= m_start + FRAME);
    if (wea && occ == CAP) m_ovf = 1;
    if (do_pop) begin
      m_byte  = m_q.pop_front();
      m_start = cyc;
      m_have  = 1;
    end
    if (wea && occ < CAP) m_q.push_back(d);
  endfunction

  function automatic logic m_tx();
    int k;
    if (m_have && cyc > m_start && cyc <= m_start + FRAME) begin
      k = (cyc - m_start - 1) / CPB;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_byte[k-1];
    end
    return 1'b1;
  endfunction

  function automatic logic m_busy();
    return (m_q.size() > 0) || (m_have && cyc < m_start + FRAME);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic wea, input logic [31:0] dat);
    Rst      = rst;
    mmio_wea = wea;
    mmio_dat = dat;
    @(posedge clk);
    cyc++;
    model_edge(rst, wea, dat[7:0]);
    @(negedge clk);
    chk("tx", tx, m_tx());
    chk("busy", tx_busy, m_busy());
    chk("full", tx_full, logic'(m_q.size() == CAP));
    chk("ovf", tx_overflow, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step(1'b0, 1'b0, 32'h0);
  endtask

  typedef struct {
    logic [31:0] dat;
    logic [9:0]  frame;  // line level per bit slot, slot 0 (start) in bit 0
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    int n;
    int r;
    logic [9:0] fr;

    vecs[0] = '{32'h0000_00A5, 10'b1101001010};
    vecs[1] = '{32'hDEAD_BE42, 10'b1010000100};
    vecs[2] = '{32'h0000_0055, 10'b1010101010};
    vecs[3] = '{32'h0000_00FF, 10'b1111111110};
    vecs[4] = '{32'hFFFF_FF00, 10'b1000000000};

    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0077);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_full", tx_full, 1'b0);
    chk("rst_ovf", tx_overflow, 1'b0);
    idle(3);
    chk("rst_prio", tx_busy, 1'b0);

    // Single frames: latency, bit pattern and busy release.
    for (int v = 0; v < 5; v++) begin
      idle(45);
      step(1'b0, 1'b1, vecs[v].dat);
      n  = cyc;
      fr = vecs[v].frame;
      step(1'b0, 1'b0, 32'h0);
      chk("latency", tx, 1'b1);
      for (int k = 0; k < FRAME; k++) begin
        step(1'b0, 1'b0, 32'h0);
        chk("frame", tx, fr[k/CPB]);
        if (k == FRAME - 2) chk("busy_hold", tx_busy, 1'b1);
      end
      chk("busy_clear", tx_busy, 1'b0);
    end

    // Back-to-back frames with no idle gap.
    idle(45);
    step(1'b0, 1'b1, 32'h0000_0055);
    n = cyc;
`ifndef UART_TX_FIFO_EN
    step(1'b0, 1'b0, 32'h0);
`endif
    step(1'b0, 1'b1, 32'h0000_000F);
    run_to(n + 41);
    chk("b2b_stop", tx, 1'b1);
    step(1'b0, 1'b0, 32'h0);
    chk("b2b_start", tx, 1'b0);
    run_to(n + 80);
    chk("b2b_busy", tx_busy, 1'b1);
    step(1'b0, 1'b0, 32'h0);
    chk("b2b_done", tx_busy, 1'b0);

    // Buffer overflow.
    step(1'b1, 1'b0, 32'h0);
    idle(2);
`ifdef UART_TX_FIFO_EN
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, i);
    chk("fifo_full", tx_full, 1'b1);
    chk("fifo_noovf", tx_overflow, 1'b0);
    step(1'b0, 1'b1, 32'h6);
    chk("fifo_ovf", tx_overflow, 1'b1);
    idle(5 * FRAME + 10);
    chk("fifo_drain", tx_busy, 1'b0);
`else
    step(1'b0, 1'b1, 32'h11);
    idle(5);
    step(1'b0, 1'b1, 32'h22);
    chk("hold_full", tx_full, 1'b1);
    chk("hold_noovf", tx_overflow, 1'b0);
    step(1'b0, 1'b1, 32'h33);
    chk("hold_ovf", tx_overflow, 1'b1);
    idle(2 * FRAME + 10);
    chk("hold_drain", tx_busy, 1'b0);
`endif
    chk("ovf_sticky", tx_overflow, 1'b1);

    // Reset in the middle of an 0xFF frame with more bytes queued.
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_00FF);
    n = cyc;
    step(1'b0, 1'b1, 32'h0000_0000);
    step(1'b0, 1'b1, 32'h0000_0081);
    run_to(n + 17);
    step(1'b1, 1'b0, 32'h0);
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    chk("abort_full", tx_full, 1'b0);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("post_rst_tx", tx, 1'b1);
    end

    // Random traffic with varying write density and rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 300; i++) begin
        r = $urandom_range(0, 999);
        step(logic'(r < 3), logic'($urandom_range(0, 99) < blk * 4 + 1), $urandom);
      end
    end
    idle(DEPTH * FRAME + 50);
    chk("final_idle", tx_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
